// File: rtl/mem_cmd_master.sv
// Buffers client read/write commands in a FIFO and issues them one at a time to a single-port memory.
// Latency: read pushed into an empty FIFO returns rsp_valid 4 cycles later; one command per 3 cycles.
// Backpressure: cmd_ready drops when the FIFO is full; responses have none (client must take rsp_valid).
module mem_cmd_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [WIDTH-1:0]      cmd_wdata,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic                  m_valid,
   output logic                  m_wr_rd,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [WIDTH-1:0]      m_wdata,
   input  logic                  m_ready,
   input  logic [WIDTH-1:0]      m_rdata,
   output logic                  busy,
   output logic                  err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int ENT_W = 1 + ADDR_WIDTH + WIDTH;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Each entry holds {wr_rd, addr, wdata}
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             rdy_en;

   state_t           state;
   logic [TMR_W-1:0] timer;

   // rdy_en keeps cmd_ready low during reset without routing rst into the datapath.
   // cmd_ready depends only on the current count, so a pop never frees a slot in the same cycle.
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = rdy_en & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state == ST_IDLE) & ~empty;
   assign busy      = ~empty | (state != ST_IDLE);

   // Command storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
      end
   end

   // Wrapping pointers and occupancy count; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Issue FSM: one-cycle m_valid pulse, wait for m_ready or time out, registered response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         m_valid   <= 1'b0;
         m_wr_rd   <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         err       <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  {m_wr_rd, m_addr, m_wdata} <= fifo_mem[rd_ptr];
                  m_valid <= 1'b1;
                  timer   <= '0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // m_valid is still high only on the first WAIT edge, where the
               // memory is sampling the request and m_ready is not yet meaningful.
               if (m_valid) begin
                  m_valid <= 1'b0;
                  timer   <= timer + 1'b1;
               end else if (m_ready) begin
                  if (!m_wr_rd) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= m_rdata;
                     rsp_addr  <= m_addr;
                  end
                  state <= ST_IDLE;
               end else if (timer == TMR_W'(TIMEOUT)) begin
                  // Give up on this command: flag it and move on without a response.
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
